// File: rtl/collapse_array.sv
// Measure-once storage array: each slot holds a basis-masked word that
// collapses on its first read; repeated wrong-basis reads lock the block.
module collapse_array #(
  parameter int DATA_W      = 256,
  parameter int BASIS_W     = 8,
  parameter int N_SLOTS     = 4,
  parameter int LOCK_THRESH = 3,
  localparam int SLOT_W     = (N_SLOTS > 2) ? $clog2(N_SLOTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_valid,
  output logic                  arm_ready,
  input  logic [SLOT_W-1:0]     arm_slot,
  input  logic [DATA_W-1:0]     arm_value,
  input  logic [BASIS_W-1:0]    arm_basis,
  input  logic                  rd_valid,
  input  logic [SLOT_W-1:0]     rd_slot,
  input  logic [BASIS_W-1:0]    rd_basis,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_match,
  output logic [SLOT_W-1:0]     rsp_slot,
  output logic [2*N_SLOTS-1:0]  slot_state,
  output logic                  locked
);

  localparam int FC_W = (LOCK_THRESH > 1) ? $clog2(LOCK_THRESH + 1) : 1;
  localparam int REPS = DATA_W / BASIS_W;
  localparam logic [SLOT_W:0] SLOT_LIM = (SLOT_W + 1)'(N_SLOTS);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'b00,
    S_ARMED     = 2'b01,
    S_COLLAPSED = 2'b10
  } slot_st_e;

  slot_st_e            r_st       [N_SLOTS];
  logic [DATA_W-1:0]   r_data     [N_SLOTS];
  logic [BASIS_W-1:0]  r_basis    [N_SLOTS];
  slot_st_e            w_st_nx    [N_SLOTS];
  logic [DATA_W-1:0]   w_data_nx  [N_SLOTS];
  logic [BASIS_W-1:0]  w_basis_nx [N_SLOTS];

  logic [FC_W-1:0]     r_fail_cnt, w_fail_nx;
  logic                r_locked, w_lock_nx;
  logic                r_rsp_valid, r_rsp_match;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_nx;
  logic [SLOT_W-1:0]   r_rsp_slot;

  logic                w_rd_acc, w_rd_in, w_arm_in, w_arm_busy, w_arm_fire;
  logic                w_hit, w_match, w_wrong;
  slot_st_e            w_sel_st;
  logic [DATA_W-1:0]   w_sel_data, w_arm_word;
  logic [BASIS_W-1:0]  w_sel_basis;

  function automatic logic [DATA_W-1:0] mask(input logic [BASIS_W-1:0] b);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < REPS; k++) m[k*BASIS_W +: BASIS_W] = b;
    return m;
  endfunction

  always_comb begin
    w_rd_acc    = rd_valid && !r_locked;
    w_rd_in     = {1'b0, rd_slot} < SLOT_LIM;
    w_arm_in    = {1'b0, arm_slot} < SLOT_LIM;
    w_sel_st    = S_EMPTY;
    w_sel_data  = '0;
    w_sel_basis = '0;
    w_arm_busy  = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (rd_slot == SLOT_W'(i)) begin
        w_sel_st    = r_st[i];
        w_sel_data  = r_data[i];
        w_sel_basis = r_basis[i];
      end
      if (arm_slot == SLOT_W'(i) && r_st[i] == S_ARMED) w_arm_busy = 1'b1;
    end

    // Read wins a same-slot collision, even when the read itself targets an idle slot.
    arm_ready  = !r_locked && w_arm_in && !w_arm_busy && !(rd_valid && rd_slot == arm_slot);
    w_arm_fire = arm_valid && arm_ready;
    w_arm_word = arm_value ^ mask(arm_basis);

    w_hit     = w_rd_acc && w_rd_in && (w_sel_st == S_ARMED);
    w_match   = w_hit && (rd_basis == w_sel_basis);
    w_wrong   = w_hit && !w_match;
    w_fail_nx = r_fail_cnt + FC_W'(w_wrong);
    w_lock_nx = r_locked || (w_wrong && (w_fail_nx == FC_W'(LOCK_THRESH)));

    w_rsp_data_nx = w_match ? (w_sel_data ^ mask(rd_basis)) : '0;

    // Priority per slot: lockout wipe, then read collapse, then arm.
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      w_st_nx[i]    = r_st[i];
      w_data_nx[i]  = r_data[i];
      w_basis_nx[i] = r_basis[i];
      if (w_arm_fire && arm_slot == SLOT_W'(i)) begin
        w_st_nx[i]    = S_ARMED;
        w_data_nx[i]  = w_arm_word;
        w_basis_nx[i] = arm_basis;
      end
      if (w_hit && rd_slot == SLOT_W'(i)) begin
        w_st_nx[i]    = S_COLLAPSED;
        w_data_nx[i]  = '0;
        w_basis_nx[i] = '0;
      end
      if (w_lock_nx && !r_locked) begin
        w_st_nx[i]    = S_COLLAPSED;
        w_data_nx[i]  = '0;
        w_basis_nx[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        r_st[i]    <= S_EMPTY;
        r_data[i]  <= '0;
        r_basis[i] <= '0;
      end
      r_fail_cnt  <= '0;
      r_locked    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_match <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_slot  <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        r_st[i]    <= w_st_nx[i];
        r_data[i]  <= w_data_nx[i];
        r_basis[i] <= w_basis_nx[i];
      end
      r_fail_cnt  <= w_fail_nx;
      r_locked    <= w_lock_nx;
      r_rsp_valid <= w_rd_acc;
      r_rsp_match <= w_match;
      r_rsp_data  <= w_rsp_data_nx;
      if (w_rd_acc) r_rsp_slot <= rd_slot;
    end
  end

  always_comb begin
    slot_state = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) slot_state[2*i +: 2] = r_st[i];
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_match = r_rsp_match;
  assign rsp_slot  = r_rsp_slot;
  assign locked    = r_locked;

endmodule

// File: tb/tb_collapse_array.sv
// Directed and randomized checks of collapse_array against a plaintext-level
// reference model (model keeps plaintext + basis, never the masked word).
module tb_collapse_array;

  logic         clk, rst;
  logic         arm_valid, arm_ready;
  logic [1:0]   arm_slot;
  logic [255:0] arm_value;
  logic [7:0]   arm_basis;
  logic         rd_valid;
  logic [1:0]   rd_slot;
  logic [7:0]   rd_basis;
  logic         rsp_valid, rsp_match, locked;
  logic [255:0] rsp_data;
  logic [1:0]   rsp_slot;
  logic [7:0]   slot_state;

  collapse_array #(.DATA_W(256), .BASIS_W(8), .N_SLOTS(4), .LOCK_THRESH(3)) dut (
    .clk(clk), .rst(rst),
    .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_slot(arm_slot),
    .arm_value(arm_value), .arm_basis(arm_basis),
    .rd_valid(rd_valid), .rd_slot(rd_slot), .rd_basis(rd_basis),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_match(rsp_match),
    .rsp_slot(rsp_slot), .slot_state(slot_state), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 empty, 1 armed, 2 collapsed
  int           m_st    [4];
  logic [255:0] m_plain [4];
  logic [7:0]   m_basis [4];
  int           m_fail;
  bit           m_locked;
  bit           e_vld, e_match;
  logic [255:0] e_data;
  logic [1:0]   e_slot;

  function automatic logic [255:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i] = 0; m_plain[i] = '0; m_basis[i] = '0;
    end
    m_fail = 0; m_locked = 0;
    e_vld = 0; e_match = 0; e_data = '0; e_slot = '0;
  endtask

  task automatic check_outputs();
    logic [7:0] ss;
    ss = '0;
    for (int i = 0; i < 4; i++) ss[2*i +: 2] = m_st[i][1:0];
    chk("rsp_valid", 256'(rsp_valid), 256'(e_vld));
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_match", 256'(rsp_match), 256'(e_match));
    chk("rsp_slot", 256'(rsp_slot), 256'(e_slot));
    chk("slot_state", 256'(slot_state), 256'(ss));
    chk("locked", 256'(locked), 256'(m_locked));
    for (int i = 0; i < 4; i++)
      chk("stored_word", dut.r_data[i], (m_st[i] == 1) ? (m_plain[i] ^ rep(m_basis[i])) : 256'd0);
  endtask

  task automatic step(input bit av, input logic [1:0] as, input logic [255:0] aval,
                      input logic [7:0] ab, input bit rv, input logic [1:0] rs,
                      input logic [7:0] rb);
    bit rdy;
    arm_valid = av; arm_slot = as; arm_value = aval; arm_basis = ab;
    rd_valid = rv; rd_slot = rs; rd_basis = rb;
    #1;
    rdy = !m_locked && (m_st[as] != 1) && !(rv && rs == as);
    chk("arm_ready", 256'(arm_ready), 256'(rdy));
    @(posedge clk);
    if (!m_locked && rv) begin
      e_vld = 1; e_slot = rs; e_data = '0; e_match = 0;
      if (m_st[rs] == 1) begin
        if (rb == m_basis[rs]) begin
          e_data = m_plain[rs]; e_match = 1;
        end else m_fail++;
        m_st[rs] = 2; m_plain[rs] = '0; m_basis[rs] = '0;
      end
    end else begin
      e_vld = 0; e_data = '0; e_match = 0;
    end
    if (av && rdy) begin
      m_st[as] = 1; m_plain[as] = aval; m_basis[as] = ab;
    end
    if (!m_locked && m_fail >= 3) begin
      m_locked = 1;
      for (int i = 0; i < 4; i++) begin
        m_st[i] = 2; m_plain[i] = '0; m_basis[i] = '0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(0, 2'd0, '0, 8'h00, 0, 2'd0, 8'h00);
  endtask

  // Reset asserted mid-cycle; outputs checked while it is still held.
  task automatic do_reset();
    rst = 1'b1;
    arm_valid = 0; rd_valid = 0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] bsel [4];

  initial begin
    bsel[0] = 8'h5A; bsel[1] = 8'h33; bsel[2] = 8'hFF; bsel[3] = 8'h00;
    rst = 1'b1; arm_valid = 0; rd_valid = 0;
    arm_slot = '0; arm_value = '0; arm_basis = '0; rd_slot = '0; rd_basis = '0;
    #12;
    do_reset();

    // Correct-basis read returns plaintext once and collapses the slot
    step(1, 2'd1, {8{32'hDEADBEEF}}, 8'h5A, 0, 2'd0, 8'h00);
    step(0, 2'd0, '0, 8'h00, 1, 2'd1, 8'h5A);
    chk("r036_data", rsp_data, {8{32'hDEADBEEF}});
    chk("r036_state", 256'(slot_state[3:2]), 256'd2);
    idle();

    // Wrong basis collapses with no data; later right basis gets nothing
    step(1, 2'd2, rnd256(), 8'h33, 0, 2'd0, 8'h00);
    step(0, 2'd0, '0, 8'h00, 1, 2'd2, 8'h34);
    step(0, 2'd0, '0, 8'h00, 1, 2'd2, 8'h33);
    chk("r037_match", 256'(rsp_match), 256'd0);

    // Same-slot collision: read wins, slot0 stays empty
    step(1, 2'd0, rnd256(), 8'h11, 1, 2'd0, 8'h11);
    chk("r038_slot0", 256'(slot_state[1:0]), 256'd0);
    // Re-arm collapsed slot1, then arm slot3 while reading slot1
    step(1, 2'd1, rnd256(), 8'h77, 0, 2'd0, 8'h00);
    step(1, 2'd3, rnd256(), 8'h44, 1, 2'd1, 8'h77);
    chk("r038_both", 256'(slot_state), 256'({2'b01, 2'b10, 2'b10, 2'b00}));

    // Masked storage: zero plaintext with basis FF stores all-ones
    step(1, 2'd0, '0, 8'hFF, 0, 2'd0, 8'h00);
    chk("r041_store", dut.r_data[0], {256{1'b1}});
    idle();

    // Reset while the response of a correct read is on the port
    step(0, 2'd0, '0, 8'h00, 1, 2'd0, 8'hFF);
    do_reset();
    idle();
    chk("r040_state", 256'(slot_state), 256'd0);

    // Read in flight when reset arrives is dropped
    step(1, 2'd2, rnd256(), 8'h5A, 0, 2'd0, 8'h00);
    rd_valid = 1; rd_slot = 2'd2; rd_basis = 8'h5A;
    #2;
    do_reset();
    idle();
    idle();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), rnd256(),
                bsel[$urandom_range(0, 3)], $urandom_range(0, 9) < 4,
                2'($urandom_range(0, 3)), bsel[$urandom_range(0, 3)]);
    end

    // Lockout after three wrong-basis reads
    do_reset();
    step(1, 2'd0, rnd256(), 8'h01, 0, 2'd0, 8'h00);
    step(1, 2'd1, rnd256(), 8'h02, 0, 2'd0, 8'h00);
    step(1, 2'd2, rnd256(), 8'h03, 0, 2'd0, 8'h00);
    step(1, 2'd3, rnd256(), 8'h04, 1, 2'd0, 8'h99);
    step(0, 2'd0, '0, 8'h00, 1, 2'd1, 8'h99);
    chk("r039_prelock", 256'(locked), 256'd0);
    step(0, 2'd0, '0, 8'h00, 1, 2'd2, 8'h99);
    chk("r039_locked", 256'(locked), 256'd1);
    step(1, 2'd0, rnd256(), 8'h05, 1, 2'd3, 8'h04);
    step(0, 2'd0, '0, 8'h00, 1, 2'd3, 8'h04);
    chk("r039_norsp", 256'(rsp_valid), 256'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
